// File: rtl/divider_ratio_meter.sv
// divider_ratio_meter
// Measures a divided clock (fdiv) in units of the fast clock (fin): the period
// between successive rising edges of fdiv and the number of fin cycles fdiv was
// high within that period. Also reports frequency lock and counter saturation.
//
// Build option: define DRM_GLITCH_FILTER_EN to accept an fdiv level change
// only after it has been stable for two fin cycles. This rejects one-cycle
// pulses at the cost of one extra cycle of edge latency.
//
// Output handshake: valid is a one-cycle strobe with no back-pressure. While
// valid is high, period and high_time carry the new measurement; they then hold
// that value until the next valid pulse (or reset).
module divider_ratio_meter #(
    parameter int W           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         fin,
    input  logic         reset,
    input  logic         fdiv,
    output logic [W-1:0] period,
    output logic [W-1:0] high_time,
    output logic         valid,
    output logic         locked,
    output logic         overflow,
    output logic [1:0]   fsm_state
);

    localparam logic [1:0] SEEK = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] LOW  = 2'd2;

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] CNT_ONE = W'(1);

    // After reset the synchronizer holds zeros that were never sampled from
    // fdiv. Edge detection stays disarmed until the chain and the previous-level
    // flop hold genuine samples, so a high fdiv at release is not a fake edge.
    localparam int               ARM_CYCLES = SYNC_STAGES + 1;
    localparam int               ARM_W      = $clog2(ARM_CYCLES + 1);
    localparam logic [ARM_W-1:0] ARM_DONE   = ARM_W'(ARM_CYCLES);
    localparam logic [ARM_W-1:0] ARM_ONE    = ARM_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl;
    logic                   lvl_q;
    logic [ARM_W-1:0]       arm_cnt;
    logic                   armed;
    logic                   rise;
    logic                   fall;

    logic [1:0]             state;
    logic [W-1:0]           per_cnt;
    logic [W-1:0]           hi_cnt;

    logic                   sat;
    logic                   start;
    logic                   close;

    // Synchronize fdiv into the fin domain.
    always_ff @(posedge fin) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], fdiv};
        end
    end

    assign lvl = sync_q[SYNC_STAGES-1];

    // Remember the previous synchronized level for edge detection.
    always_ff @(posedge fin) begin
        if (reset) begin
            lvl_q <= 1'b0;
        end else begin
            lvl_q <= lvl;
        end
    end

    // Count out the post-reset warm-up before edges are trusted.
    always_ff @(posedge fin) begin
        if (reset) begin
            arm_cnt <= '0;
        end else if (!armed) begin
            arm_cnt <= arm_cnt + ARM_ONE;
        end
    end

    assign armed = (arm_cnt == ARM_DONE);

`ifdef DRM_GLITCH_FILTER_EN
    // Filtered level: follows the synchronized level only once it has held
    // the same value for two consecutive cycles.
    logic flt;

    // Track the accepted (filtered) level of fdiv.
    always_ff @(posedge fin) begin
        if (reset) begin
            flt <= 1'b0;
        end else if (!armed) begin
            flt <= lvl;
        end else if (lvl == lvl_q) begin
            flt <= lvl;
        end
    end

    assign rise = armed && lvl && lvl_q && !flt;
    assign fall = armed && !lvl && !lvl_q && flt;
`else
    assign rise = armed && lvl && !lvl_q;
    assign fall = armed && !lvl && lvl_q;
`endif

    // Saturation outranks a rising edge arriving in the same cycle: the
    // measurement is abandoned rather than reported with a clipped value.
    assign sat   = (state != SEEK) && (per_cnt == CNT_MAX);
    assign start = (state == SEEK) && rise;
    // A rising edge in HIGH means the falling edge was lost; it still closes
    // the period exactly as a rising edge in LOW does.
    assign close = (state != SEEK) && rise && !sat;

    // Measurement FSM: SEEK waits for a first edge, HIGH/LOW follow fdiv.
    always_ff @(posedge fin) begin
        if (reset) begin
            state <= SEEK;
        end else if (sat) begin
            state <= SEEK;
        end else begin
            case (state)
                SEEK: begin
                    if (rise) begin
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    if (rise) begin
                        state <= HIGH;
                    end else if (fall) begin
                        state <= LOW;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state <= HIGH;
                    end
                end
                default: begin
                    state <= SEEK;
                end
            endcase
        end
    end

    assign fsm_state = state;

    // Period and high-time counters. Both restart at 1 on an accepted rising
    // edge so that the count seen at the next edge equals the edge distance.
    always_ff @(posedge fin) begin
        if (reset) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (start || close) begin
            per_cnt <= CNT_ONE;
            hi_cnt  <= CNT_ONE;
        end else if (!sat) begin
            if (state == HIGH) begin
                per_cnt <= per_cnt + CNT_ONE;
                if (!fall) begin
                    hi_cnt <= hi_cnt + CNT_ONE;
                end
            end else if (state == LOW) begin
                per_cnt <= per_cnt + CNT_ONE;
            end
        end
    end

    // Result registers, valid strobe, lock tracking and sticky overflow.
    always_ff @(posedge fin) begin
        if (reset) begin
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            locked    <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            valid <= close;
            if (close) begin
                period    <= per_cnt;
                high_time <= hi_cnt;
                locked    <= (per_cnt == period);
                overflow  <= 1'b0;
            end else if (sat) begin
                locked   <= 1'b0;
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_divider_ratio_meter.sv
// tb_divider_ratio_meter
// Drives fdiv one bit per fin cycle. Every driven bit is fed to a reference
// model that works on the bit stream itself (edge positions, distances, count
// of high bits), pushes expected output states and valid pulses into queues,
// and a negedge monitor pops and compares them against the DUT.
// Honours DRM_GLITCH_FILTER_EN the same way the design does.
module tb_divider_ratio_meter;

    localparam int W   = 4;
    localparam int S   = 2;
    localparam int MAX = (1 << W) - 1;
    localparam int LAT = S + 1;

    typedef struct {
        int cyc;
        int per;
        int hi;
        bit lock;
        bit ovf;
    } st_t;

    typedef struct {
        int cyc;
        int per;
    } exp_t;

    logic         fin;
    logic         reset;
    logic         fdiv;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         locked;
    logic         overflow;
    logic [1:0]   fsm_state;

    int  cyc = 0;
    int  n_cmp = 0;
    int  n_err = 0;

    st_t  st_q[$];
    exp_t exp_q[$];
    st_t  cur;
    bit   cur_ok = 0;

    // reference model state
    bit m_seek = 1;
    bit m_base = 1;
    bit m_prev = 0;
    bit m_f    = 0;
    int m_r    = 0;
    int m_hi   = 0;
    int m_last = 0;
    int m_last_hi = 0;

    divider_ratio_meter #(.W(W), .SYNC_STAGES(S)) dut (
        .fin       (fin),
        .reset     (reset),
        .fdiv      (fdiv),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .locked    (locked),
        .overflow  (overflow),
        .fsm_state (fsm_state)
    );

    // clock / reset block
    initial begin
        fin   = 1'b0;
        reset = 1'b1;
        fdiv  = 1'b0;
    end
    always #5 fin = ~fin;
    always @(posedge fin) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: consumes one driven bit (and its reset flag) per cycle.
    task automatic model_step(input bit b, input bit r, input int c);
        bit rise;
        int per;
        bit lock;
        if (r) begin
            m_seek = 1; m_base = 1; m_last = 0; m_last_hi = 0;
            st_q.push_back('{c + 1, 0, 0, 1'b0, 1'b0});
            return;
        end
        if (m_base) begin
            m_base = 0; m_prev = b; m_f = b;
            return;
        end
        rise = 0;
`ifdef DRM_GLITCH_FILTER_EN
        if (b == m_prev && b != m_f) begin
            m_f  = b;
            rise = b;
        end
`else
        if (b != m_f) begin
            m_f  = b;
            rise = b;
        end
`endif
        m_prev = b;
        if (!m_seek && (c - m_r) == MAX) begin
            m_seek = 1;
            st_q.push_back('{c + LAT, m_last, m_last_hi, 1'b0, 1'b1});
        end else if (rise) begin
            if (!m_seek) begin
                per  = c - m_r;
                lock = (per == m_last);
                m_last = per;
                m_last_hi = m_hi;
                exp_q.push_back('{c + LAT, per});
                st_q.push_back('{c + LAT, per, m_hi, lock, 1'b0});
            end
            m_seek = 0;
            m_r    = c;
            m_hi   = 0;
        end
        if (!m_seek && m_f) m_hi++;
    endtask

    // driver tasks
    task automatic drive(input bit b, input bit r);
        @(posedge fin);
        #1;
        fdiv  = b;
        reset = r;
        model_step(b, r, cyc);
    endtask

    task automatic run_div(input int hi_n, input int lo_n, input int reps);
        for (int k = 0; k < reps; k++) begin
            for (int i = 0; i < hi_n; i++) drive(1'b1, 1'b0);
            for (int i = 0; i < lo_n; i++) drive(1'b0, 1'b0);
        end
    endtask

    // scoreboard monitor
    always @(negedge fin) begin
        exp_t e;
        while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
            cur    = st_q.pop_front();
            cur_ok = 1;
        end
        if (cur_ok) begin
            check("period", period, cur.per);
            check("high_time", high_time, cur.hi);
            check("locked", locked, cur.lock);
            check("overflow", overflow, cur.ovf);
            if (valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("valid_cycle", cyc, e.cyc);
                    check("valid_period", period, e.per);
                end
            end else begin
                check("valid_level", valid, 0);
            end
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                check("missing_valid", cyc, e.cyc);
            end
        end
    end

    // stimulus
    initial begin
        int hn;
        int ln;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0);

        // divide-by-8
        run_div(4, 4, 6);
        // divide-by-5 with a 3/2 split
        run_div(3, 2, 6);
        // divide-by-8 locked, then switch to divide-by-6
        run_div(4, 4, 5);
        run_div(3, 3, 4);

        // overflow: one rising edge then fdiv held low
        run_div(3, 25, 1);
        check("ovf_set", overflow, 1);
        check("ovf_unlock", locked, 0);
        run_div(3, 3, 4);
        check("ovf_cleared", overflow, 0);

        // reset for one cycle in the middle of a high phase
        run_div(4, 4, 4);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        check("rst_period", period, 0);
        check("rst_high_time", high_time, 0);
        check("rst_valid", valid, 0);
        check("rst_locked", locked, 0);
        check("rst_overflow", overflow, 0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0);
        run_div(4, 4, 4);

        // one-cycle high glitch inside the low phase of divide-by-8
        drive(1'b1, 1'b0); drive(1'b1, 1'b0); drive(1'b1, 1'b0); drive(1'b1, 1'b0);
        drive(1'b0, 1'b0); drive(1'b1, 1'b0); drive(1'b0, 1'b0); drive(1'b0, 1'b0);
        run_div(4, 4, 3);

        // randomized divide ratios and duty cycles
        for (int t = 0; t < 12; t++) begin
            hn = $urandom_range(2, 6);
            ln = $urandom_range(2, 6);
            run_div(hn, ln, $urandom_range(2, 5));
        end

        // drain
        for (int i = 0; i < 30; i++) drive(1'b0, 1'b0);
        repeat (4) @(negedge fin);
        check("drain_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
